// File: rtl/dbg_sba_manager.sv
// System Bus Access engine behind sbcs/sbaddress0/sbdata0: decodes DMI accesses
// and runs single 8/16/32-bit transfers on a valid/grant/rvalid bus manager port.
module dbg_sba_manager #(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        dmi_req,
    input  logic [7:0]  dmi_addr,
    input  logic        dmi_we,
    input  logic [31:0] dmi_wdata,
    output logic        dmi_rvalid,
    output logic [31:0] dmi_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [15:0] CNT_MAX = 16'(BUS_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] sbaddr, sbdata;
    logic [2:0]  access, error;
    logic        readonaddr, readondata, autoinc, busyerror;
    logic [15:0] cnt;
    logic        done, timeout;

    function automatic logic [3:0] lane_be(input logic [2:0] acc, input logic [1:0] off);
        case (acc)
            3'd0:    lane_be = 4'b0001 << off;
            3'd1:    lane_be = 4'b0011 << off;
            default: lane_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [2:0] acc, input logic [31:0] d);
        case (acc)
            3'd0:    lane_wdata = {4{d[7:0]}};
            3'd1:    lane_wdata = {2{d[15:0]}};
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [2:0] acc, input logic [1:0] off,
                                               input logic [31:0] d);
        logic [31:0] sh;
        sh = d >> {off, 3'b000};
        case (acc)
            3'd0:    lane_rdata = {24'd0, sh[7:0]};
            3'd1:    lane_rdata = {16'd0, sh[15:0]};
            default: lane_rdata = sh;
        endcase
    endfunction

    logic busy, wr_cs, wr_addr, wr_data, rd_data, clean;
    logic start_rd, start_wr, start, size_bad, align_bad, go;
    logic [31:0] start_addr, start_data, sbcs_val;
    logic [1:0]  align_mask;

    assign busy     = (state != IDLE);
    assign wr_cs    = dmi_req && dmi_we && (dmi_addr == 8'h38);
    assign wr_addr  = dmi_req && dmi_we && (dmi_addr == 8'h39);
    assign wr_data  = dmi_req && dmi_we && (dmi_addr == 8'h3c);
    assign rd_data  = dmi_req && !dmi_we && (dmi_addr == 8'h3c);
    assign clean    = !busyerror && (error == 3'd0);
    assign start_rd = !busy && clean && ((wr_addr && readonaddr) || (rd_data && readondata));
    assign start_wr = !busy && clean && wr_data;
    assign start    = start_rd || start_wr;

    // A new sbaddress0/sbdata0 value takes effect for the transfer it launches
    assign start_addr = wr_addr ? dmi_wdata : sbaddr;
    assign start_data = wr_data ? dmi_wdata : sbdata;
    assign align_mask = (access == 3'd0) ? 2'b00 : (access == 3'd1) ? 2'b01 : 2'b11;
    assign size_bad   = (access > 3'd2);
    assign align_bad  = |(start_addr[1:0] & align_mask);
    assign go         = start && !size_bad && !align_bad;

    assign sbcs_val = {3'd1, 6'd0, busyerror, busy, readonaddr, access, autoinc,
                       readondata, error, 7'd32, 5'b00111};

    // Drop the request as soon as reset is seen, not one edge later
    assign bus_req = (state == REQ) && nRst;

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: if (go) state_nxt = REQ;
            REQ: begin
                if (bus_gnt) begin
                    state_nxt = RESP;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            RESP: begin
                if (bus_rvalid) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = IDLE;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state      <= IDLE;
            sbaddr     <= '0;
            sbdata     <= '0;
            access     <= 3'd2;
            readonaddr <= 1'b0;
            readondata <= 1'b0;
            autoinc    <= 1'b0;
            busyerror  <= 1'b0;
            error      <= 3'd0;
            cnt        <= '0;
            dmi_rvalid <= 1'b0;
            dmi_rdata  <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
        end else begin
            state      <= state_nxt;
            dmi_rvalid <= dmi_req;
            if (state_nxt != state) cnt <= '0;
            else if (busy)          cnt <= cnt + 16'd1;

            dmi_rdata <= '0;
            if (dmi_req && !dmi_we) begin
                case (dmi_addr)
                    8'h38:   dmi_rdata <= sbcs_val;
                    8'h39:   dmi_rdata <= sbaddr;
                    8'h3c:   dmi_rdata <= sbdata;
                    default: dmi_rdata <= '0;
                endcase
            end

            if (wr_cs) begin
                readonaddr <= dmi_wdata[20];
                access     <= dmi_wdata[19:17];
                autoinc    <= dmi_wdata[16];
                readondata <= dmi_wdata[15];
            end

            // Hardware-raised flags win over a same-cycle W1C
            if ((wr_addr || wr_data || rd_data) && busy) busyerror <= 1'b1;
            else if (wr_cs)                              busyerror <= busyerror & ~dmi_wdata[22];

            if (start && size_bad)       error <= 3'd4;
            else if (start && align_bad) error <= 3'd3;
            else if (done && bus_err)    error <= 3'd2;
            else if (timeout)            error <= 3'd1;
            else if (wr_cs)              error <= error & ~dmi_wdata[14:12];

            if (wr_addr && !busy)
                sbaddr <= dmi_wdata;
            else if (done && !bus_err && autoinc)
                sbaddr <= sbaddr + (32'd1 << access);

            if (wr_data && !busy)
                sbdata <= dmi_wdata;
            else if (done && !bus_err && !bus_we)
                sbdata <= lane_rdata(access, sbaddr[1:0], bus_rdata);

            if (go) begin
                bus_we    <= start_wr;
                bus_addr  <= {start_addr[31:2], 2'b00};
                bus_be    <= lane_be(access, start_addr[1:0]);
                bus_wdata <= lane_wdata(access, start_data);
            end
        end
    end
endmodule

// File: tb/tb_dbg_sba_manager.sv
// Directed bench for dbg_sba_manager: hand-computed DMI readback and bus port values.
module tb_dbg_sba_manager;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        nRst = 1'b0;
    logic        dmi_req = 1'b0, dmi_we = 1'b0;
    logic [7:0]  dmi_addr = '0;
    logic [31:0] dmi_wdata = '0;
    logic        dmi_rvalid;
    logic [31:0] dmi_rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;

    int total = 0;
    int bad = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    dbg_sba_manager #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .nRst(nRst),
        .dmi_req(dmi_req), .dmi_addr(dmi_addr), .dmi_we(dmi_we), .dmi_wdata(dmi_wdata),
        .dmi_rvalid(dmi_rvalid), .dmi_rdata(dmi_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dmi_write(input logic [7:0] a, input logic [31:0] d);
        dmi_req = 1'b1; dmi_we = 1'b1; dmi_addr = a; dmi_wdata = d;
        tick();
        dmi_req = 1'b0; dmi_we = 1'b0;
    endtask

    task automatic dmi_read(input logic [7:0] a, output logic [31:0] d);
        dmi_req = 1'b1; dmi_we = 1'b0; dmi_addr = a;
        tick();
        dmi_req = 1'b0;
        chk("dmi_rvalid", {31'd0, dmi_rvalid}, 32'd1);
        d = dmi_rdata;
    endtask

    task automatic bus_complete(input logic [31:0] rdata, input logic err);
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = err;
        tick();
        bus_rvalid = 1'b0; bus_err = 1'b0;
    endtask

    initial begin
        // reset state
        tick(); tick();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_rvalid", {31'd0, dmi_rvalid}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        nRst = 1'b1;
        dmi_read(8'h38, rd); chk("rst_sbcs", rd, 32'h20040407);
        dmi_read(8'h39, rd); chk("rst_sbaddr", rd, 32'd0);
        dmi_read(8'h3c, rd); chk("rst_sbdata", rd, 32'd0);
        dmi_read(8'h10, rd); chk("other_addr", rd, 32'd0);

        // 1: 32-bit write, minimum latency
        dmi_write(8'h38, 32'h00040000);
        chk("t1_wr_rdata", dmi_rdata, 32'd0);
        dmi_write(8'h39, 32'h00001000);
        chk("t1_no_req", {31'd0, bus_req}, 32'd0);
        dmi_write(8'h3c, 32'hDEADBEEF);
        chk("t1_req", {31'd0, bus_req}, 32'd1);
        chk("t1_we", {31'd0, bus_we}, 32'd1);
        chk("t1_addr", bus_addr, 32'h00001000);
        chk("t1_be", {28'd0, bus_be}, 32'hF);
        chk("t1_wdata", bus_wdata, 32'hDEADBEEF);
        bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
        chk("t1_req_drop", {31'd0, bus_req}, 32'd0);
        bus_rvalid = 1'b1; tick(); bus_rvalid = 1'b0;
        dmi_read(8'h38, rd); chk("t1_sbcs", rd, 32'h20040407);

        // 2: byte read on address write, lane 3
        dmi_write(8'h38, 32'h00100000);
        dmi_write(8'h39, 32'h00002003);
        chk("t2_req", {31'd0, bus_req}, 32'd1);
        chk("t2_we", {31'd0, bus_we}, 32'd0);
        chk("t2_addr", bus_addr, 32'h00002000);
        chk("t2_be", {28'd0, bus_be}, 32'h8);
        bus_complete(32'hAABBCCDD, 1'b0);
        dmi_read(8'h3c, rd); chk("t2_sbdata", rd, 32'h000000AA);

        // 3: readondata + autoincrement burst
        dmi_write(8'h38, 32'h00058000);
        dmi_write(8'h39, 32'h00000100);
        chk("t3_no_req", {31'd0, bus_req}, 32'd0);
        dmi_read(8'h3c, rd); chk("t3_rd0", rd, 32'h000000AA);
        chk("t3_addr0", bus_addr, 32'h00000100);
        bus_complete(32'h11111111, 1'b0);
        dmi_read(8'h3c, rd); chk("t3_rd1", rd, 32'h11111111);
        chk("t3_addr1", bus_addr, 32'h00000104);
        bus_complete(32'h22222222, 1'b0);
        dmi_read(8'h3c, rd); chk("t3_rd2", rd, 32'h22222222);
        chk("t3_addr2", bus_addr, 32'h00000108);
        bus_complete(32'h33333333, 1'b0);
        dmi_read(8'h39, rd); chk("t3_sbaddr", rd, 32'h0000010C);
        dmi_write(8'h38, 32'h00040000);
        dmi_read(8'h3c, rd); chk("t3_rd3", rd, 32'h33333333);
        chk("t3_no_req2", {31'd0, bus_req}, 32'd0);

        // 4: busyerror while grant withheld
        dmi_write(8'h39, 32'h00003000);
        dmi_write(8'h3c, 32'h12345678);
        chk("t4_req", {31'd0, bus_req}, 32'd1);
        dmi_write(8'h3c, 32'h00000055);
        chk("t4_wdata_hold", bus_wdata, 32'h12345678);
        bus_complete(32'd0, 1'b0);
        dmi_read(8'h38, rd); chk("t4_sbcs_be", rd, 32'h20440407);
        dmi_read(8'h3c, rd); chk("t4_dropped", rd, 32'h12345678);
        dmi_write(8'h3c, 32'h00000099);
        chk("t4_blocked", {31'd0, bus_req}, 32'd0);
        dmi_write(8'h38, 32'h00440000);
        dmi_read(8'h38, rd); chk("t4_sbcs_clr", rd, 32'h20040407);
        dmi_write(8'h3c, 32'h00000099);
        chk("t4_req2", {31'd0, bus_req}, 32'd1);
        chk("t4_wdata2", bus_wdata, 32'h00000099);
        bus_complete(32'd0, 1'b0);

        // 5: alignment, size, bus error, timeout
        dmi_write(8'h38, 32'h00020000);
        dmi_write(8'h39, 32'h00001001);
        dmi_write(8'h3c, 32'h0000ABCD);
        chk("t5_align_noreq", {31'd0, bus_req}, 32'd0);
        dmi_read(8'h38, rd); chk("t5_align_err", rd, 32'h20023407);
        dmi_write(8'h38, 32'h00067000);
        dmi_write(8'h3c, 32'h00000001);
        chk("t5_size_noreq", {31'd0, bus_req}, 32'd0);
        dmi_read(8'h38, rd); chk("t5_size_err", rd, 32'h20064407);
        dmi_write(8'h38, 32'h00047000);
        dmi_write(8'h39, 32'h00004000);
        dmi_write(8'h3c, 32'h00000001);
        chk("t5_req", {31'd0, bus_req}, 32'd1);
        bus_complete(32'hFFFFFFFF, 1'b1);
        dmi_read(8'h38, rd); chk("t5_bus_err", rd, 32'h20042407);
        dmi_read(8'h39, rd); chk("t5_addr_kept", rd, 32'h00004000);
        dmi_write(8'h38, 32'h00047000);
        dmi_write(8'h3c, 32'h00000002);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t5_req_hold", {31'd0, bus_req}, 32'd1);
        tick();
        chk("t5_req_timeout", {31'd0, bus_req}, 32'd0);
        dmi_read(8'h38, rd); chk("t5_to_err", rd, 32'h20041407);
        bus_rvalid = 1'b1; bus_rdata = 32'hCAFEF00D; tick(); bus_rvalid = 1'b0;
        dmi_read(8'h3c, rd); chk("t5_late_rvalid", rd, 32'h00000002);
        dmi_write(8'h38, 32'h00047000);

        // 6: reset in RESP
        dmi_write(8'h3c, 32'h00000077);
        bus_gnt = 1'b1; tick(); bus_gnt = 1'b0;
        dmi_write(8'h38, 32'h00058000);
        nRst = 1'b0;
        tick();
        chk("t6_bus_req", {31'd0, bus_req}, 32'd0);
        chk("t6_bus_addr", bus_addr, 32'd0);
        chk("t6_bus_be", {28'd0, bus_be}, 32'd0);
        nRst = 1'b1;
        dmi_read(8'h38, rd); chk("t6_sbcs", rd, 32'h20040407);
        dmi_read(8'h39, rd); chk("t6_sbaddr", rd, 32'd0);
        dmi_read(8'h3c, rd); chk("t6_sbdata", rd, 32'd0);
        chk("t6_no_req", {31'd0, bus_req}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
